// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD down-counter with load, start/stop, borrow pulse and
// selectable terminal behaviour (wrap to 99 or stop in DONE).
module bcd_countdown_timer (
    input  logic       input_CLK,
    input  logic       input_RST,
    input  logic       input_LOAD,
    input  logic [7:0] input_DATA,
    input  logic       input_START,
    input  logic       input_STOP,
    input  logic       input_ENA,
    input  logic       input_WRAP,
    output logic [7:0] output_Y,
    output logic       output_BORROW,
    output logic       output_BUSY,
    output logic       output_DONE
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic       borrow_q, borrow_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic [3:0] load_tens, load_ones;
    assign load_tens = (input_DATA[7:4] > 4'd9) ? 4'd9 : input_DATA[7:4];
    assign load_ones = (input_DATA[3:0] > 4'd9) ? 4'd9 : input_DATA[3:0];

    always_comb begin
        state_d  = state_q;
        tens_d   = tens_q;
        ones_d   = ones_q;
        borrow_d = 1'b0;

        if (input_LOAD) begin
            tens_d  = load_tens;
            ones_d  = load_ones;
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!input_STOP && input_START) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (input_STOP) begin
                        state_d = ST_IDLE;
                    end else if (input_ENA) begin
                        if (tens_q == 4'd0 && ones_q == 4'd0) begin
                            // Tick taken at 00: borrow, then wrap or terminate.
                            borrow_d = 1'b1;
                            if (input_WRAP) begin
                                tens_d = 4'd9;
                                ones_d = 4'd9;
                            end else begin
                                state_d = ST_DONE;
                            end
                        end else if (ones_q == 4'd0) begin
                            ones_d = 4'd9;
                            tens_d = tens_q - 4'd1;
                        end else begin
                            ones_d = ones_q - 4'd1;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge input_CLK or posedge input_RST) begin
        if (input_RST) begin
            state_q  <= ST_IDLE;
            tens_q   <= 4'd0;
            ones_q   <= 4'd0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tens_q   <= tens_d;
            ones_q   <= ones_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign output_Y      = {tens_q, ones_q};
    assign output_BORROW = borrow_q;
    assign output_BUSY   = busy_q;
    assign output_DONE   = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Table-driven scoreboard bench for bcd_countdown_timer, plus a hand-written
// asynchronous reset sequence.
module tb_bcd_countdown_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic [7:0] data = 8'h00;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       ena = 1'b0;
    logic       wrap = 1'b0;
    logic [7:0] y;
    logic       borrow, busy, done;

    always #5 clk = ~clk;

    bcd_countdown_timer dut (
        .input_CLK    (clk),
        .input_RST    (rst),
        .input_LOAD   (load),
        .input_DATA   (data),
        .input_START  (start),
        .input_STOP   (stop),
        .input_ENA    (ena),
        .input_WRAP   (wrap),
        .output_Y     (y),
        .output_BORROW(borrow),
        .output_BUSY  (busy),
        .output_DONE  (done)
    );

    typedef struct packed {
        logic       load;
        logic [7:0] data;
        logic       start;
        logic       stop;
        logic       ena;
        logic       wrap;
        logic [7:0] y;
        logic       borrow;
        logic       busy;
        logic       done;
    } vec_t;

    typedef struct packed {
        logic [7:0]  y;
        logic        borrow;
        logic        busy;
        logic        done;
        logic [15:0] idx;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [7:0] to_bcd(input int n);
        logic [3:0] t, o;
        t = 4'(n / 10);
        o = 4'(n % 10);
        return {t, o};
    endfunction

    task automatic add(input logic l, input logic [7:0] d, input logic s, input logic p,
                       input logic e, input logic w, input logic [7:0] ey,
                       input logic eb, input logic ebu, input logic edn);
        vec_t v;
        v.load = l;  v.data = d;  v.start = s; v.stop = p; v.ena = e; v.wrap = w;
        v.y = ey;    v.borrow = eb; v.busy = ebu; v.done = edn;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s row %0d: got %h want %h", nm, idx, got, want);
        end
    endtask

    task automatic run_row(input int i);
        exp_t e;
        exp_t g;
        load  = vecs[i].load;
        data  = vecs[i].data;
        start = vecs[i].start;
        stop  = vecs[i].stop;
        ena   = vecs[i].ena;
        wrap  = vecs[i].wrap;
        e.y = vecs[i].y; e.borrow = vecs[i].borrow; e.busy = vecs[i].busy;
        e.done = vecs[i].done; e.idx = 16'(i);
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        chk("y",      int'(g.idx), y,             g.y);
        chk("borrow", int'(g.idx), {7'd0, borrow}, {7'd0, g.borrow});
        chk("busy",   int'(g.idx), {7'd0, busy},   {7'd0, g.busy});
        chk("done",   int'(g.idx), {7'd0, done},   {7'd0, g.done});
        $display("row %0d: y=%h borrow=%b busy=%b done=%b", i, y, borrow, busy, done);
    endtask

    initial begin
        //   load data  st sp en wr   y     bo bu dn
        // Digit borrow across tens
        add(1, 8'h30, 0, 0, 0, 0,  8'h30, 0, 0, 0);
        add(0, 8'h00, 1, 0, 1, 0,  8'h30, 0, 1, 0);
        for (int k = 29; k >= 19; k--)
            add(0, 8'h00, 0, 0, 1, 0, to_bcd(k), 0, 1, 0);
        // Stop mode
        add(1, 8'h02, 0, 0, 0, 0,  8'h02, 0, 0, 0);
        add(0, 8'h00, 1, 0, 0, 0,  8'h02, 0, 1, 0);
        add(0, 8'h00, 0, 0, 1, 0,  8'h01, 0, 1, 0);
        add(0, 8'h00, 0, 0, 1, 0,  8'h00, 0, 1, 0);
        add(0, 8'h00, 0, 0, 1, 0,  8'h00, 1, 0, 1);
        add(0, 8'h00, 0, 0, 1, 0,  8'h00, 0, 0, 1);
        add(0, 8'h00, 1, 0, 1, 0,  8'h00, 0, 0, 1);
        add(0, 8'h00, 0, 1, 1, 0,  8'h00, 0, 0, 1);
        add(1, 8'h05, 0, 0, 1, 0,  8'h05, 0, 0, 0);
        // Wrap mode: first borrow, then a second after 100 more ticks
        add(1, 8'h01, 0, 0, 0, 1,  8'h01, 0, 0, 0);
        add(0, 8'h00, 1, 0, 0, 1,  8'h01, 0, 1, 0);
        add(0, 8'h00, 0, 0, 1, 1,  8'h00, 0, 1, 0);
        add(0, 8'h00, 0, 0, 1, 1,  8'h99, 1, 1, 0);
        for (int k = 98; k >= 0; k--)
            add(0, 8'h00, 0, 0, 1, 1, to_bcd(k), 0, 1, 0);
        add(0, 8'h00, 0, 0, 1, 1,  8'h99, 1, 1, 0);
        add(0, 8'h00, 0, 0, 1, 1,  8'h98, 0, 1, 0);
        // Load clamp and priority over stop/tick
        add(1, 8'h60, 0, 0, 0, 0,  8'h60, 0, 0, 0);
        add(0, 8'h00, 1, 0, 0, 0,  8'h60, 0, 1, 0);
        add(0, 8'h00, 0, 0, 1, 0,  8'h59, 0, 1, 0);
        add(1, 8'hBC, 0, 1, 1, 0,  8'h99, 0, 0, 0);
        add(1, 8'hA3, 0, 0, 0, 0,  8'h93, 0, 0, 0);
        add(1, 8'h5F, 0, 0, 0, 0,  8'h59, 0, 0, 0);
        // Start from 00; load at 00 with tick suppresses borrow
        add(1, 8'h00, 0, 0, 0, 0,  8'h00, 0, 0, 0);
        add(0, 8'h00, 1, 0, 1, 0,  8'h00, 0, 1, 0);
        add(1, 8'h00, 0, 0, 1, 0,  8'h00, 0, 0, 0);
        add(0, 8'h00, 1, 0, 0, 0,  8'h00, 0, 1, 0);
        add(0, 8'h00, 0, 0, 1, 0,  8'h00, 1, 0, 1);
        // Stop/start hold; start ignored in run
        add(1, 8'h58, 0, 0, 0, 0,  8'h58, 0, 0, 0);
        add(0, 8'h00, 1, 0, 0, 0,  8'h58, 0, 1, 0);
        add(0, 8'h00, 0, 0, 1, 0,  8'h57, 0, 1, 0);
        add(0, 8'h00, 0, 1, 1, 0,  8'h57, 0, 0, 0);
        add(0, 8'h00, 0, 0, 1, 0,  8'h57, 0, 0, 0);
        add(0, 8'h00, 1, 0, 1, 0,  8'h57, 0, 1, 0);
        add(0, 8'h00, 0, 0, 1, 0,  8'h56, 0, 1, 0);
        add(0, 8'h00, 1, 0, 1, 0,  8'h55, 0, 1, 0);
        // Lead-in to the mid-count reset
        add(1, 8'h47, 0, 0, 0, 0,  8'h47, 0, 0, 0);
        add(0, 8'h00, 1, 0, 0, 0,  8'h47, 0, 1, 0);
        add(0, 8'h00, 0, 0, 1, 0,  8'h46, 0, 1, 0);
        add(0, 8'h00, 0, 0, 1, 0,  8'h45, 0, 1, 0);
        add(0, 8'h00, 0, 0, 1, 0,  8'h44, 0, 1, 0);

        // Power-on reset
        #2 rst = 1'b1;
        #1;
        chk("reset_y",    -1, y,              8'h00);
        chk("reset_busy", -1, {7'd0, busy},   8'h00);
        chk("reset_done", -1, {7'd0, done},   8'h00);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++)
            run_row(i);

        // Asynchronous reset mid-count, between edges, ENA still high
        #2 rst = 1'b1;
        #1;
        chk("async_y",      -2, y,              8'h00);
        chk("async_busy",   -2, {7'd0, busy},   8'h00);
        chk("async_done",   -2, {7'd0, done},   8'h00);
        chk("async_borrow", -2, {7'd0, borrow}, 8'h00);
        $display("async reset: y=%h borrow=%b busy=%b done=%b", y, borrow, busy, done);
        @(posedge clk);
        #1 rst = 1'b0;
        ena = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_y",    -3, y,            8'h00);
        chk("post_reset_busy", -3, {7'd0, busy}, 8'h00);
        $display("post reset: y=%h busy=%b", y, busy);
        chk("sb_empty", -4, 8'(sb.size()), 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
